// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: operand memory and multiplier bus between sequencer and datapath
interface matmul_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int NE      = MAX_DIM * MAX_DIM;
  logic                       mem_rd_o;
  logic [ADDR_WIDTH-1:0]      mem_addr_o;
  logic [BUS_WIDTH-1:0]       mem_rdata_i;
  logic                       mul_start_o;
  logic [2:0]                 mul_n_o;
  logic [2:0]                 mul_k_o;
  logic [2:0]                 mul_m_o;
  logic [NE*DATA_WIDTH-1:0]   a_matrix_o;
  logic [NE*DATA_WIDTH-1:0]   b_matrix_o;
  logic                       mul_finish_i;
  logic [NE*BUS_WIDTH-1:0]    mul_c_i;
  logic [NE-1:0]              mul_flags_i;
  modport master (
    output mem_rd_o, mem_addr_o, mul_start_o, mul_n_o, mul_k_o, mul_m_o, a_matrix_o, b_matrix_o,
    input  mem_rdata_i, mul_finish_i, mul_c_i, mul_flags_i
  );
  modport slave (
    input  mem_rd_o, mem_addr_o, mul_start_o, mul_n_o, mul_k_o, mul_m_o, a_matrix_o, b_matrix_o,
    output mem_rdata_i, mul_finish_i, mul_c_i, mul_flags_i
  );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: fetches operands, runs the multiplier under a watchdog, captures/accumulates the result
module matmul_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  go_i,
  input  logic [2:0]            n_dim_i,
  input  logic [2:0]            k_dim_i,
  input  logic [2:0]            m_dim_i,
  input  logic                  acc_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  matmul_sequencer_if.master    bus,
  output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*BUS_WIDTH-1:0] res_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0]           flags_o
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int TIMEOUT = 4 * MAX_DIM + 4;
  localparam int NE      = MAX_DIM * MAX_DIM;
  localparam int CW      = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               n_q, n_d, k_q, k_d, m_q, m_d;
  logic                     acc_q, acc_d, err_q, err_d;
  logic [NE*DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [NE*BUS_WIDTH-1:0]  res_q, res_d, sum;
  logic [NE-1:0]            flags_q, flags_d, ov;
  logic                     dims_ok;
  assign dims_ok = (n_dim_i != 3'd0) && (n_dim_i <= 3'(MAX_DIM)) &&
                   (k_dim_i != 3'd0) && (k_dim_i <= 3'(MAX_DIM)) &&
                   (m_dim_i != 3'd0) && (m_dim_i <= 3'(MAX_DIM));
  for (genvar e = 0; e < NE; e++) begin : g_acc
    assign sum[e*BUS_WIDTH +: BUS_WIDTH] = res_q[e*BUS_WIDTH +: BUS_WIDTH] + bus.mul_c_i[e*BUS_WIDTH +: BUS_WIDTH];
    assign ov[e] = (res_q[(e+1)*BUS_WIDTH-1] == bus.mul_c_i[(e+1)*BUS_WIDTH-1]) &&
                   (sum[(e+1)*BUS_WIDTH-1] != res_q[(e+1)*BUS_WIDTH-1]);
  end
  // next-state, operand capture and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (go_i) begin
        if (dims_ok) begin
          state_d = LOAD;
          cnt_d   = '0;
          n_d     = n_dim_i;
          k_d     = k_dim_i;
          m_d     = m_dim_i;
          acc_d   = acc_i;
        end else err_d = 1'b1;
      end
      LOAD: begin
        cnt_d = cnt_q + CW'(1);
        for (int r = 0; r < MAX_DIM; r++) begin
          if (cnt_q == CW'(r + 1)) a_d[r*BUS_WIDTH +: BUS_WIDTH] = bus.mem_rdata_i;
          if (cnt_q == CW'(MAX_DIM + r + 1)) b_d[r*BUS_WIDTH +: BUS_WIDTH] = bus.mem_rdata_i;
        end
        if (cnt_q == CW'(2 * MAX_DIM)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.mul_finish_i) begin
          state_d = DONE;
          res_d   = acc_q ? sum : bus.mul_c_i;
          flags_d = bus.mul_flags_i | (acc_q ? ov : '0);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      k_q     <= k_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end
  assign busy_o          = state_q != IDLE;
  assign done_o          = state_q == DONE;
  assign err_o           = err_q;
  assign bus.mem_rd_o    = (state_q == LOAD) && (cnt_q < CW'(2 * MAX_DIM));
  assign bus.mem_addr_o  = bus.mem_rd_o ? ADDR_WIDTH'(cnt_q) : '0;
  assign bus.mul_start_o = state_q == RUN;
  assign bus.mul_n_o     = n_q;
  assign bus.mul_k_o     = k_q;
  assign bus.mul_m_o     = m_q;
  assign bus.a_matrix_o  = a_q;
  assign bus.b_matrix_o  = b_q;
  assign res_o           = res_q;
  assign flags_o         = flags_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: randomized runs checked against a behavioural sequencer/multiplier model
module tb_matmul_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        go_i = 1'b0;
  logic [2:0]  n_dim_i = '0, k_dim_i = '0, m_dim_i = '0;
  logic        acc_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [63:0] res_o;
  logic [3:0]  flags_o;
  logic [15:0] mem [4];
  logic [63:0] res_m = '0;
  logic [3:0]  flg_m = '0;
  int          n_cmp = 0, n_err = 0;

  matmul_sequencer_if #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  matmul_sequencer #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .go_i(go_i),
    .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i), .acc_i(acc_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .bus(bus), .res_o(res_o), .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  // operand memory: data one cycle after the read strobe
  always @(posedge clk_i) if (bus.mem_rd_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[1:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] matmul(input int n, input int k, input int m);
    logic [63:0] c = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int s = 0;
        if (i < n && j < m)
          for (int p = 0; p < k; p++) s += int'(mem[i][8*p +: 8]) * int'(mem[2+p][8*j +: 8]);
        c[(2*i+j)*16 +: 16] = 16'(s);
      end
    return c;
  endfunction

  task automatic model_capture(input logic acc, input logic [63:0] c, input logic [3:0] fl);
    for (int e = 0; e < 4; e++) begin
      logic [15:0] o = res_m[e*16 +: 16];
      logic [15:0] v = c[e*16 +: 16];
      int s = int'($signed(o)) + int'($signed(v));
      res_m[e*16 +: 16] = acc ? 16'(s) : v;
      flg_m[e] = fl[e] | (acc && (s > 32767 || s < -32768));
    end
  endtask

  // lat < 0: multiplier never finishes
  task automatic do_run(input logic [2:0] n, input logic [2:0] k, input logic [2:0] m, input logic acc,
                        input int lat, input logic [3:0] fl, input bit frc, input logic [63:0] cf);
    int rd = 0, st = 0, dn = 0, er = 0, cyc;
    logic [63:0] c = frc ? cf : matmul(int'(n), int'(k), int'(m));
    @(negedge clk_i);
    go_i = 1'b1; n_dim_i = n; k_dim_i = k; m_dim_i = m; acc_i = acc;
    @(negedge clk_i);
    go_i = 1'b0;
    check("first_rd", {63'd0, bus.mem_rd_o}, 64'd1);
    for (cyc = 0; cyc < 200; cyc++) begin
      rd += int'(bus.mem_rd_o);
      if (bus.mul_start_o) begin
        st++;
        if (st == 1) begin
          check("mul_dims", {55'd0, bus.mul_n_o, bus.mul_k_o, bus.mul_m_o}, {55'd0, n, k, m});
          check("a_matrix", {32'd0, bus.a_matrix_o}, {32'd0, mem[1], mem[0]});
          check("b_matrix", {32'd0, bus.b_matrix_o}, {32'd0, mem[3], mem[2]});
        end
      end
      dn += int'(done_o);
      er += int'(err_o);
      bus.mul_finish_i = bus.mul_start_o && (st == lat);
      bus.mul_c_i      = bus.mul_finish_i ? c : $urandom;
      bus.mul_flags_i  = bus.mul_finish_i ? fl : 4'($urandom);
      if (dn != 0 || er != 0) break;
      @(negedge clk_i);
    end
    bus.mul_finish_i = 1'b0;
    check("budget", 64'(cyc < 200), 64'd1);
    check("rd_cycles", 64'(rd), 64'd4);
    check("start_cycles", 64'(st), lat < 0 ? 64'd12 : 64'(lat));
    check("start_end", {63'd0, bus.mul_start_o}, 64'd0);
    check("done_err", {62'd0, dn[0], er[0]}, lat < 0 ? 64'd1 : 64'd2);
    if (lat >= 0) model_capture(acc, c, fl);
    check("res", res_o, res_m);
    check("flags", {60'd0, flags_o}, {60'd0, flg_m});
    @(negedge clk_i);
    check("after", {61'd0, busy_o, done_o, err_o}, 64'd0);
  endtask

  task automatic bad_go(input logic [2:0] n, input logic [2:0] k, input logic [2:0] m);
    int rd = 0, bz = 0;
    @(negedge clk_i);
    go_i = 1'b1; n_dim_i = n; k_dim_i = k; m_dim_i = m; acc_i = 1'($urandom);
    @(negedge clk_i);
    go_i = 1'b0;
    check("bad_err", {63'd0, err_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      rd += int'(bus.mem_rd_o);
      bz += int'(busy_o);
      @(negedge clk_i);
    end
    check("bad_err_pulse", {63'd0, err_o}, 64'd0);
    check("bad_rd_busy", 64'(rd + bz), 64'd0);
    check("bad_res", res_o, res_m);
  endtask

  initial begin
    bus.mul_finish_i = 1'b0;
    bus.mul_c_i = '0;
    bus.mul_flags_i = '0;
    #12;
    check("rst_state", {58'd0, busy_o, done_o, err_o, bus.mem_rd_o, bus.mul_start_o, |flags_o}, 64'd0);
    check("rst_res", res_o, 64'd0);
    check("rst_a", {32'd0, bus.a_matrix_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem[0] = 16'h0201; mem[1] = 16'h0403; mem[2] = 16'h0605; mem[3] = 16'h0807;
    do_run(3'd2, 3'd2, 3'd2, 1'b0, 3, 4'd0, 1'b0, '0);
    check("dir_res", res_o, {16'd50, 16'd43, 16'd22, 16'd19});
    do_run(3'd2, 3'd2, 3'd2, 1'b1, 5, 4'd0, 1'b0, '0);
    check("dir_acc", res_o, {16'd100, 16'd86, 16'd44, 16'd38});
    do_run(3'd2, 3'd2, 3'd2, 1'b0, 2, 4'd0, 1'b1, 64'h0000_0000_0000_7FFF);
    do_run(3'd2, 3'd2, 3'd2, 1'b1, 2, 4'd0, 1'b1, 64'h0000_0000_0000_0001);
    check("ovf_res", res_o, 64'h0000_0000_0000_8000);
    check("ovf_flags", {60'd0, flags_o}, 64'd1);
    bad_go(3'd0, 3'd2, 3'd2);
    bad_go(3'd2, 3'd2, 3'd3);
    do_run(3'd1, 3'd2, 3'd2, 1'b0, -1, 4'd0, 1'b0, '0);
    @(negedge clk_i);
    go_i = 1'b1; n_dim_i = 3'd2; k_dim_i = 3'd2; m_dim_i = 3'd2; acc_i = 1'b0;
    @(negedge clk_i);
    go_i = 1'b0;
    repeat (7) @(negedge clk_i);
    check("mid_run", {63'd0, bus.mul_start_o}, 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst", {58'd0, busy_o, done_o, err_o, bus.mem_rd_o, bus.mul_start_o, |flags_o}, 64'd0);
    check("async_rst_res", res_o | {32'd0, bus.a_matrix_o | bus.b_matrix_o}, 64'd0);
    res_m = '0;
    flg_m = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_run(3'd2, 3'd2, 3'd2, 1'b0, 4, 4'b1010, 1'b0, '0);
    for (int t = 0; t < 30; t++) begin
      for (int a = 0; a < 4; a++) mem[a] = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        logic [2:0] bd = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(3, 7));
        case ($urandom_range(0, 2))
          0: bad_go(bd, 3'd1, 3'd2);
          1: bad_go(3'd2, bd, 3'd1);
          default: bad_go(3'd1, 3'd2, bd);
        endcase
      end else begin
        logic [63:0] rc = {$urandom, $urandom};
        bit fc = $urandom_range(0, 2) == 0;
        do_run(3'($urandom_range(1, 2)), 3'($urandom_range(1, 2)), 3'($urandom_range(1, 2)),
               1'($urandom), $urandom_range(0, 7) == 0 ? -1 : $urandom_range(1, 10),
               4'($urandom), fc, rc);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
